// File: rtl/sspx_slv_sync_pkg.sv
`default_nettype none
// sspx_slv_sync_pkg -- state encoding, default widths and frame-length helper for the SSP slave.
// Rev 1.0
package sspx_slv_sync_pkg;

   localparam int SSPX_DEF_RA_W  = 3;
   localparam int SSPX_DEF_DAT_W = 12;
   localparam int SSPX_DEF_BC_W  = 5;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_DATA = 3'd2,
      ST_DONE = 3'd3,
      ST_WAIT = 3'd4
   } sspx_state_e;

   function automatic int sspx_frame_len(input int ra_w, input int dat_w);
      return ra_w + 1 + dat_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sspx_sync.sv
`default_nettype none
// sspx_sync -- 2-FF synchroniser with one history stage for rise/fall detection, W bits wide.
// Rev 1.0
module sspx_sync #(
   parameter int W = 3
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o,
   output logic [W-1:0] rise_o,
   output logic [W-1:0] fall_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;
   logic [W-1:0] hist_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         meta_q <= '0;
         sync_q <= '0;
         hist_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         hist_q <= sync_q;
      end
   end

   assign q_o    = sync_q;
   assign rise_o = sync_q & ~hist_q;
   assign fall_o = ~sync_q & hist_q;

endmodule
`default_nettype wire

// File: rtl/sspx_slv_sync.sv
`default_nettype none
// sspx_slv_sync -- oversampled SPI mode-0 slave bridging a serial master to a register file.
// Rev 1.0; define SSPX_SLV_AUTOINC_EN for auto-incrementing burst transfers.
module sspx_slv_sync
   import sspx_slv_sync_pkg::*;
#(
   parameter int RA_W  = SSPX_DEF_RA_W,
   parameter int DAT_W = SSPX_DEF_DAT_W,
   parameter int BC_W  = SSPX_DEF_BC_W
) (
   input  logic             Clk,
   input  logic             Rst_N,
   input  logic             SSEL,
   input  logic             SCK,
   input  logic             MOSI,
   output logic             MISO,
   output logic             MOE,
   output logic [RA_W-1:0]  RA,
   output logic             WnR,
   output logic             RE,
   output logic             WE,
   output logic [DAT_W-1:0] DI,
   input  logic [DAT_W-1:0] DO,
   output logic             EOC,
   output logic             Abort,
   output logic [BC_W-1:0]  BC
);

   localparam int HDR_LEN   = RA_W + 1;
   localparam int FRAME_LEN = sspx_frame_len(RA_W, DAT_W);
   localparam int RX_W      = (HDR_LEN > DAT_W) ? HDR_LEN : DAT_W;
   localparam logic [BC_W-1:0] BC_HDR        = BC_W'(HDR_LEN);
   localparam logic [BC_W-1:0] BC_HDR_LAST   = BC_W'(HDR_LEN - 1);
   localparam logic [BC_W-1:0] BC_FRAME_LAST = BC_W'(FRAME_LEN - 1);

   logic [2:0] sync_q, sync_rise, sync_fall;
   logic       ssel_s, ssel_rise, ssel_fall, sck_rise, sck_fall, mosi_s;

   sspx_sync #(.W(3)) u_sync (
      .clk_i   (Clk),
      .rst_n_i (Rst_N),
      .d_i     ({SSEL, SCK, MOSI}),
      .q_o     (sync_q),
      .rise_o  (sync_rise),
      .fall_o  (sync_fall)
   );

   assign ssel_s    = sync_q[2];
   assign ssel_rise = sync_rise[2];
   assign ssel_fall = sync_fall[2];
   assign sck_rise  = sync_rise[1];
   assign sck_fall  = sync_fall[1];
   assign mosi_s    = sync_q[0];

   sspx_state_e      state_q, state_d;
   logic [BC_W-1:0]  bc_q, bc_d;
   logic [RX_W-1:0]  rx_q, rx_d, rx_shift;
   logic [DAT_W-1:0] tx_q, tx_d;
   logic [DAT_W-1:0] di_q, di_d;
   logic [RA_W-1:0]  ra_q, ra_d;
   logic [1:0]       settle_q, settle_d;
   logic miso_q, miso_d, wnr_q, wnr_d, burst_q, burst_d;
   logic re_q, re_d, we_q, we_d, eoc_q, eoc_d, abort_q, abort_d;

   assign rx_shift = {rx_q[RX_W-2:0], mosi_s};

   always_comb begin
      state_d  = state_q;
      bc_d     = bc_q;
      rx_d     = rx_q;
      tx_d     = tx_q;
      di_d     = di_q;
      ra_d     = ra_q;
      wnr_d    = wnr_q;
      miso_d   = miso_q;
      burst_d  = burst_q;
      re_d     = 1'b0;
      we_d     = 1'b0;
      eoc_d    = 1'b0;
      abort_d  = 1'b0;
      settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;

      if (ssel_fall) begin
         // Only a frame that received some bits of the current word is truncated.
         if ((state_q == ST_HDR || state_q == ST_DATA) && (bc_q != (burst_q ? BC_HDR : '0)))
            abort_d = 1'b1;
         state_d = ST_IDLE;
         bc_d    = '0;
         burst_d = 1'b0;
         miso_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               bc_d    = '0;
               burst_d = 1'b0;
               miso_d  = 1'b0;
               // A rise seen while the synchroniser is still filling after reset is a frame already in flight.
               if (ssel_rise)
                  state_d = (settle_q == 2'd3) ? ST_HDR : ST_WAIT;
            end
            ST_HDR: begin
               if (sck_rise) begin
                  rx_d = rx_shift;
                  bc_d = bc_q + BC_W'(1);
                  if (bc_q == BC_HDR_LAST) begin
                     ra_d    = rx_shift[RA_W:1];
                     wnr_d   = rx_shift[0];
                     re_d    = 1'b1;
                     state_d = ST_DATA;
                  end
               end else if (sck_fall) begin
                  miso_d = 1'b0;
               end
            end
            ST_DATA: begin
               if (sck_rise) begin
                  rx_d = rx_shift;
                  bc_d = bc_q + BC_W'(1);
                  if (bc_q == BC_FRAME_LAST) begin
                     di_d    = rx_shift[DAT_W-1:0];
                     eoc_d   = 1'b1;
                     we_d    = wnr_q;
                     miso_d  = 1'b0;
                     state_d = ST_DONE;
                  end
               end else if (sck_fall) begin
                  miso_d = tx_q[DAT_W-1];
                  tx_d   = {tx_q[DAT_W-2:0], 1'b0};
               end
            end
            ST_DONE: begin
`ifdef SSPX_SLV_AUTOINC_EN
               // WE for the finished word is out now; advance the address only afterwards.
               ra_d    = ra_q + RA_W'(1);
               re_d    = 1'b1;
               bc_d    = BC_HDR;
               burst_d = 1'b1;
               state_d = ST_DATA;
`else
               miso_d  = 1'b0;
`endif
            end
            ST_WAIT: begin
               if (!ssel_s)
                  state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (re_q)
         tx_d = DO;
   end

   always_ff @(posedge Clk) begin
      if (!Rst_N) begin
         state_q  <= ST_IDLE;
         bc_q     <= '0;
         rx_q     <= '0;
         tx_q     <= '0;
         di_q     <= '0;
         ra_q     <= '0;
         wnr_q    <= 1'b0;
         miso_q   <= 1'b0;
         burst_q  <= 1'b0;
         settle_q <= 2'd0;
         re_q     <= 1'b0;
         we_q     <= 1'b0;
         eoc_q    <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         bc_q     <= bc_d;
         rx_q     <= rx_d;
         tx_q     <= tx_d;
         di_q     <= di_d;
         ra_q     <= ra_d;
         wnr_q    <= wnr_d;
         miso_q   <= miso_d;
         burst_q  <= burst_d;
         settle_q <= settle_d;
         re_q     <= re_d;
         we_q     <= we_d;
         eoc_q    <= eoc_d;
         abort_q  <= abort_d;
      end
   end

   assign MISO  = miso_q;
   assign MOE   = ssel_s;
   assign RA    = ra_q;
   assign WnR   = wnr_q;
   assign RE    = re_q;
   assign WE    = we_q;
   assign DI    = di_q;
   assign EOC   = eoc_q;
   assign Abort = abort_q;
   assign BC    = bc_q;

   logic w_unused;
   assign w_unused = ^{sync_q[1], sync_rise[0], sync_fall[0], rx_q[RX_W-1]};

endmodule
`default_nettype wire

// File: tb/tb_sspx_slv_sync.sv
`default_nettype none
// tb_sspx_slv_sync -- randomized frame-level bench with a register-file model and strobe monitor.
module tb_sspx_slv_sync;

   logic        clk = 1'b0;
   logic        rst_n, SSEL, SCK, MOSI;
   logic        MISO, MOE, WnR, RE, WE, EOC, Abort;
   logic [2:0]  RA;
   logic [11:0] DI, DO;
   logic [4:0]  BC;
   logic [11:0] rf [0:7];

   always #5 clk = ~clk;
   assign DO = rf[RA];

   sspx_slv_sync #(.RA_W(3), .DAT_W(12), .BC_W(5)) dut (
      .Clk(clk), .Rst_N(rst_n), .SSEL(SSEL), .SCK(SCK), .MOSI(MOSI),
      .MISO(MISO), .MOE(MOE), .RA(RA), .WnR(WnR), .RE(RE), .WE(WE),
      .DI(DI), .DO(DO), .EOC(EOC), .Abort(Abort), .BC(BC)
   );

   int chk = 0, pass = 0;
   int clr_gen = 0, seen_gen = 0;
   int re_ra[$];
   int we_rec[$];
   int eoc_cnt = 0, abort_cnt = 0;
   logic fbits [0:63];
   logic mbits [0:63];
   int fn, rst_at, bc_end;
   int m_ra = 0, m_wnr = 0, m_di = 0;

   always @(negedge clk) begin
      if (clr_gen != seen_gen) begin
         seen_gen = clr_gen;
         re_ra.delete();
         we_rec.delete();
         eoc_cnt = 0;
         abort_cnt = 0;
      end else begin
         if (RE)    re_ra.push_back(int'(RA));
         if (WE)    we_rec.push_back((int'(RA) << 12) | int'(DI));
         if (EOC)   eoc_cnt++;
         if (Abort) abort_cnt++;
      end
   end

   task automatic clk_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_logs();
      clr_gen++;
      clk_n(2);
   endtask

   task automatic put_bits(input int pos, input int nb, input int val);
      for (int k = 0; k < nb; k++) fbits[pos+k] = val[nb-1-k];
   endtask

   task automatic build_frame(input int ra, input int wnr, input int data);
      put_bits(0, 3, ra);
      put_bits(3, 1, wnr);
      put_bits(4, 12, data);
      fn = 16;
   endtask

   // Master side: mode 0, SCK period 20 Clk, MISO sampled just before each rise.
   task automatic run_frame();
      SSEL = 1'b1;
      clk_n(10);
      for (int i = 0; i < fn; i++) begin
         MOSI = fbits[i];
         if (i == rst_at) begin
            rst_n = 1'b0;
            clr_gen++;
            clk_n(2);
            rst_n = 1'b1;
            clk_n(8);
         end else begin
            clk_n(10);
         end
         mbits[i] = MISO;
         SCK = 1'b1;
         clk_n(10);
         SCK = 1'b0;
      end
      clk_n(10);
      bc_end = int'(BC);
      SSEL = 1'b0;
      clk_n(10);
   endtask

   function automatic int miso_word(input int pos, input int nb);
      int w = 0;
      for (int k = 0; k < nb; k++) w = (w << 1) | int'(mbits[pos+k]);
      return w;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      clk_n(3);
      chk++; if ({MISO, MOE, WnR, RE, WE, EOC, Abort} !== 7'b0) $display("FAIL reset_bits: got %b expected 0", {MISO, MOE, WnR, RE, WE, EOC, Abort}); else pass++;
      chk++; if (RA !== 3'd0) $display("FAIL reset_ra: got %0d expected 0", RA); else pass++;
      chk++; if (DI !== 12'd0) $display("FAIL reset_di: got %03h expected 000", DI); else pass++;
      chk++; if (BC !== 5'd0) $display("FAIL reset_bc: got %0d expected 0", BC); else pass++;
      rst_n = 1'b1;
      clk_n(5);
   endtask

   task automatic test_frame(input string nm, input int ra, input int wnr, input int data, input int dov);
      int re_first, we_exp;
      rf[ra] = 12'(dov);
      clear_logs();
      build_frame(ra, wnr, data);
      rst_at = -1;
      run_frame();
      m_ra = ra; m_wnr = wnr; m_di = data;
      re_first = (re_ra.size() > 0) ? re_ra[0] : -1;
      we_exp = (ra << 12) | data;
      chk++; if (miso_word(4, 12) !== dov) $display("FAIL %s_miso: got %03h expected %03h", nm, miso_word(4, 12), dov); else pass++;
      chk++; if (miso_word(0, 4) !== 0) $display("FAIL %s_miso_hdr: got %0h expected 0", nm, miso_word(0, 4)); else pass++;
      chk++; if (re_ra.size() !== 1) $display("FAIL %s_re_cnt: got %0d expected 1", nm, re_ra.size()); else pass++;
      chk++; if (re_first !== ra) $display("FAIL %s_re_ra: got %0d expected %0d", nm, re_first, ra); else pass++;
      chk++; if (we_rec.size() !== wnr) $display("FAIL %s_we_cnt: got %0d expected %0d", nm, we_rec.size(), wnr); else pass++;
      if (wnr == 1 && we_rec.size() > 0) begin
         chk++; if (we_rec[0] !== we_exp) $display("FAIL %s_we_rec: got %0h expected %0h", nm, we_rec[0], we_exp); else pass++;
      end
      chk++; if (eoc_cnt !== 1) $display("FAIL %s_eoc: got %0d expected 1", nm, eoc_cnt); else pass++;
      chk++; if (abort_cnt !== 0) $display("FAIL %s_abort: got %0d expected 0", nm, abort_cnt); else pass++;
      chk++; if (int'(DI) !== data) $display("FAIL %s_di: got %03h expected %03h", nm, DI, data); else pass++;
      chk++; if (int'(RA) !== ra || int'(WnR) !== wnr) $display("FAIL %s_ra_wnr: got %0d/%0d expected %0d/%0d", nm, RA, WnR, ra, wnr); else pass++;
      chk++; if (bc_end !== 16) $display("FAIL %s_bc_end: got %0d expected 16", nm, bc_end); else pass++;
   endtask

   task automatic test_write();
      test_frame("write", 7, 1, 'h556, 'hAA9);
   endtask

   task automatic test_read();
      test_frame("read", 2, 0, 'h123, 'h123);
   endtask

   task automatic test_random_frames();
      for (int n = 0; n < 5; n++)
         test_frame("rand", int'($urandom_range(7, 0)), int'($urandom_range(1, 0)),
                    int'($urandom_range(4095, 0)), int'($urandom_range(4095, 0)));
   endtask

   task automatic test_abort(input int nbits);
      int ra, wnr, data, exp_ra, exp_wnr, exp_re;
      ra = int'($urandom_range(7, 0)); wnr = int'($urandom_range(1, 0)); data = int'($urandom_range(4095, 0));
      rf[ra] = 12'($urandom_range(4095, 0));
      clear_logs();
      build_frame(ra, wnr, data);
      fn = nbits;
      rst_at = -1;
      run_frame();
      exp_ra  = (nbits >= 4) ? ra : m_ra;
      exp_wnr = (nbits >= 4) ? wnr : m_wnr;
      exp_re  = (nbits >= 4) ? 1 : 0;
      chk++; if (abort_cnt !== 1) $display("FAIL abort%0d_pulse: got %0d expected 1", nbits, abort_cnt); else pass++;
      chk++; if (we_rec.size() !== 0 || eoc_cnt !== 0) $display("FAIL abort%0d_we_eoc: got %0d/%0d expected 0/0", nbits, we_rec.size(), eoc_cnt); else pass++;
      chk++; if (int'(DI) !== m_di) $display("FAIL abort%0d_di: got %03h expected %03h", nbits, DI, m_di); else pass++;
      chk++; if (int'(RA) !== exp_ra || int'(WnR) !== exp_wnr) $display("FAIL abort%0d_ra_wnr: got %0d/%0d expected %0d/%0d", nbits, RA, WnR, exp_ra, exp_wnr); else pass++;
      chk++; if (re_ra.size() !== exp_re) $display("FAIL abort%0d_re: got %0d expected %0d", nbits, re_ra.size(), exp_re); else pass++;
      chk++; if (BC !== 5'd0) $display("FAIL abort%0d_bc: got %0d expected 0", nbits, BC); else pass++;
      m_ra = exp_ra; m_wnr = exp_wnr;
   endtask

   task automatic test_abort_cases();
      test_abort(9);
      for (int n = 0; n < 3; n++) test_abort(int'($urandom_range(15, 1)));
   endtask

   task automatic test_reset_midframe();
      clear_logs();
      build_frame(int'($urandom_range(7, 0)), 1, int'($urandom_range(4095, 0)));
      rst_at = 6;
      run_frame();
      rst_at = -1;
      chk++; if (re_ra.size() !== 0 || we_rec.size() !== 0) $display("FAIL rstmid_re_we: got %0d/%0d expected 0/0", re_ra.size(), we_rec.size()); else pass++;
      chk++; if (eoc_cnt !== 0 || abort_cnt !== 0) $display("FAIL rstmid_eoc_abort: got %0d/%0d expected 0/0", eoc_cnt, abort_cnt); else pass++;
      chk++; if (bc_end !== 0) $display("FAIL rstmid_bc_wait: got %0d expected 0", bc_end); else pass++;
      chk++; if (RA !== 3'd0 || DI !== 12'd0) $display("FAIL rstmid_cleared: got %0d/%03h expected 0/000", RA, DI); else pass++;
      m_ra = 0; m_wnr = 0; m_di = 0;
      test_frame("post_reset", int'($urandom_range(7, 0)), 1, int'($urandom_range(4095, 0)), int'($urandom_range(4095, 0)));
   endtask

   task automatic test_sck_idle();
      int bad = 0;
      clear_logs();
      SSEL = 1'b0;
      for (int n = 0; n < 16; n++) begin
         MOSI = 1'($urandom_range(1, 0));
         clk_n(10);
         SCK = 1'b1;
         clk_n(10);
         SCK = 1'b0;
         if (BC !== 5'd0 || MISO !== 1'b0 || MOE !== 1'b0) bad++;
      end
      chk++; if (bad !== 0) $display("FAIL idle_outputs: got %0d bad cycles expected 0", bad); else pass++;
      chk++; if (re_ra.size() + we_rec.size() + eoc_cnt + abort_cnt !== 0) $display("FAIL idle_strobes: got %0d expected 0", re_ra.size() + we_rec.size() + eoc_cnt + abort_cnt); else pass++;
      SSEL = 1'b1;
      clk_n(10);
      SSEL = 1'b0;
      clk_n(10);
      chk++; if (abort_cnt !== 0 || re_ra.size() !== 0) $display("FAIL empty_frame: got %0d/%0d expected 0/0", abort_cnt, re_ra.size()); else pass++;
   endtask

   task automatic test_burst();
      int words [0:2];
      int addrs [0:2];
      words[0] = 'h111; words[1] = 'h222; words[2] = 'h333;
      addrs[0] = 6; addrs[1] = 7; addrs[2] = 0;
      for (int k = 0; k < 3; k++) rf[addrs[k]] = 12'($urandom_range(4095, 0));
      clear_logs();
      put_bits(0, 3, 6);
      put_bits(3, 1, 1);
      for (int k = 0; k < 3; k++) put_bits(4 + 12*k, 12, words[k]);
      fn = 40;
      rst_at = -1;
      run_frame();
      chk++; if (miso_word(4, 12) !== int'(rf[6])) $display("FAIL burst_miso0: got %03h expected %03h", miso_word(4, 12), rf[6]); else pass++;
      chk++; if (abort_cnt !== 0) $display("FAIL burst_abort: got %0d expected 0", abort_cnt); else pass++;
`ifdef SSPX_SLV_AUTOINC_EN
      chk++; if (eoc_cnt !== 3) $display("FAIL burst_eoc: got %0d expected 3", eoc_cnt); else pass++;
      chk++; if (we_rec.size() !== 3) $display("FAIL burst_we_cnt: got %0d expected 3", we_rec.size()); else pass++;
      for (int k = 0; k < 3; k++) begin
         if (we_rec.size() > k) begin
            chk++; if (we_rec[k] !== ((addrs[k] << 12) | words[k])) $display("FAIL burst_we%0d: got %0h expected %0h", k, we_rec[k], (addrs[k] << 12) | words[k]); else pass++;
         end
         chk++; if (miso_word(4 + 12*k, 12) !== int'(rf[addrs[k]])) $display("FAIL burst_miso%0d: got %03h expected %03h", k, miso_word(4 + 12*k, 12), rf[addrs[k]]); else pass++;
      end
`else
      chk++; if (eoc_cnt !== 1) $display("FAIL burst_eoc: got %0d expected 1", eoc_cnt); else pass++;
      chk++; if (we_rec.size() !== 1) $display("FAIL burst_we_cnt: got %0d expected 1", we_rec.size()); else pass++;
      if (we_rec.size() > 0) begin
         chk++; if (we_rec[0] !== ((6 << 12) | 'h111)) $display("FAIL burst_we0: got %0h expected %0h", we_rec[0], (6 << 12) | 'h111); else pass++;
      end
      chk++; if (miso_word(16, 24) !== 0) $display("FAIL burst_miso_tail: got %06h expected 0", miso_word(16, 24)); else pass++;
      chk++; if (bc_end !== 16) $display("FAIL burst_bc_hold: got %0d expected 16", bc_end); else pass++;
      chk++; if (DI !== 12'h111) $display("FAIL burst_di: got %03h expected 111", DI); else pass++;
`endif
   endtask

   initial begin
      SSEL = 1'b0; SCK = 1'b0; MOSI = 1'b0; rst_n = 1'b0; rst_at = -1; fn = 0; bc_end = 0;
      for (int i = 0; i < 8; i++) rf[i] = 12'd0;
      test_reset();
      test_write();
      test_read();
      test_random_frames();
      test_abort_cases();
      test_reset_midframe();
      test_sck_idle();
      test_burst();
      $display("%0d/%0d checks passed", pass, chk);
      $finish;
   end

endmodule
`default_nettype wire
